// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle radix-2 restoring divider producing {HI=remainder, LO=quotient} for DIV/DIVU
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start_i       divide request, held by EX until the result is consumed
//   annul_i       abort request (pipeline flush)
//   signed_div_i  1=DIV (signed), 0=DIVU; only honoured when HILO_DIV_SIGNED_EN is defined
//   opdata1_i     dividend, sampled on the accepting edge
//   opdata2_i     divisor, sampled on the accepting edge
//   result_o      {remainder, quotient}, valid while ready_o=1, else 0
//   ready_o       result valid
//   stallreq_o    combinational pipeline stall request
//
// Build option: define HILO_DIV_SIGNED_EN to enable signed division; otherwise every divide is unsigned.
module hilo_div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*DATA_W:0] partial, partial_n;
  logic [DATA_W-1:0] divisor, diff, quot, rem, quot_f, rem_f, a_mag, b_mag;
  logic accept, last, ge, finish;
  assign accept = state == IDLE && start_i && !annul_i;
  assign last = cnt == CNT_W'(DATA_W - 1);
  assign finish = state == ON && !annul_i && last;
  assign stallreq_o = accept || state == ON || state == BYZERO;
  // partial = {remainder (DATA_W bits), next dividend bit, remaining dividend/quotient bits};
  // the compare uses DATA_W+1 bits so a remainder above 2**(DATA_W-1) is not truncated, while
  // the subtraction result always fits DATA_W bits once it is known to be non-negative.
  always_comb begin
    ge = partial[2*DATA_W:DATA_W] >= {1'b0, divisor};
    diff = partial[2*DATA_W-1:DATA_W] - divisor;
    partial_n = ge ? {diff, partial[DATA_W-1:0], 1'b1} : {partial[2*DATA_W-1:0], 1'b0};
    quot = partial_n[DATA_W-1:0];
    rem = partial_n[2*DATA_W:DATA_W+1];
  end
`ifdef HILO_DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quot_f = neg_q ? -quot : quot;
  assign rem_f = neg_r ? -rem : rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_r <= signed_div_i && opdata1_i[DATA_W-1];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign a_mag = opdata1_i;
  assign b_mag = opdata2_i;
  assign quot_f = quot;
  assign rem_f = rem;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (opdata2_i == '0 ? BYZERO : ON) : IDLE;
      BYZERO:  state_n = DONE;
      ON:      state_n = annul_i ? IDLE : (last ? DONE : ON);
      DONE:    state_n = start_i ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      partial <= '0;
      divisor <= '0;
      ready_o <= 1'b0;
      result_o <= '0;
    end else begin
      ready_o <= state_n == DONE;
      result_o <= finish ? {rem_f, quot_f} : (state == DONE && start_i) ? result_o : '0;
      if (accept) begin
        cnt <= '0;
        partial <= {{DATA_W{1'b0}}, a_mag, 1'b0};
        divisor <= b_mag;
      end else if (state == ON && !annul_i) begin
        cnt <= cnt + 1'b1;
        partial <= partial_n;
      end
    end
  end
endmodule

// File: tb/tb_hilo_div_seq.sv
// tb_hilo_div_seq: directed scoreboard bench for hilo_div_seq
module tb_hilo_div_seq;
  logic clk = 1'b0;
  logic rst, start_i, annul_i, signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic ready_o, stallreq_o;
  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  hilo_div_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o),
    .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb, q, r;
    logic na, nb;
    if (b == 0) return 64'h0;
`ifdef HILO_DIV_SIGNED_EN
    na = s & a[31];
    nb = s & b[31];
`else
    na = 1'b0;
    nb = 1'b0;
    if (s) na = 1'b0;
`endif
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit scramble);
    int lat;
    bit stall_ok;
    logic [63:0] exp;
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = s;
    start_i = 1'b1;
    sb.push_back(model(a, b, s));
    #1;
    stall_ok = stallreq_o === 1'b1;
    lat = 0;
    while (ready_o !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 5) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~s;
      end
      if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 0;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd2 : 64'd33);
    check({tag, " stall"}, 64'(stall_ok), 64'd1);
    check({tag, " stall_end"}, 64'(stallreq_o), 64'd0);
    exp = sb.pop_front();
    check({tag, " result"}, result_o, exp);
  endtask
  task automatic release_start(input string tag);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, " ready_drop"}, 64'(ready_o), 64'd0);
    check({tag, " result_drop"}, result_o, 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("rst ready", 64'(ready_o), 64'd0);
    check("rst result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle stall", 64'(stallreq_o), 64'd0);
    do_div("divu100_7", 32'd100, 32'd7, 1'b0, 0);
    check("divu100_7 literal", result_o, 64'h00000002_0000000E);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold ready", 64'(ready_o), 64'd1);
      check("hold result", result_o, 64'h00000002_0000000E);
    end
    release_start("divu100_7");
    do_div("divu5_0", 32'd5, 32'd0, 1'b0, 0);
    release_start("divu5_0");
    do_div("sign_case", 32'hFFFFFFF9, 32'd2, 1'b1, 0);
`ifndef HILO_DIV_SIGNED_EN
    check("sign_case literal", result_o, 64'h00000001_7FFFFFFC);
`endif
    release_start("sign_case");
    do_div("neg7_2", -32'sd7, 32'd2, 1'b1, 0);
    release_start("neg7_2");
    do_div("min_neg1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    release_start("min_neg1");
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul stall", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    check("annul stall_idle", 64'(stallreq_o), 64'd0);
    begin
      bit seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (ready_o !== 1'b0) seen = 1;
      end
      check("annul no_ready", 64'(seen), 64'd0);
    end
    do_div("scramble", 32'd987654321, 32'd12345, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("scramble hold", result_o, model(32'd987654321, 32'd12345, 1'b0));
    end
    release_start("scramble");
    @(negedge clk);
    opdata1_i = 32'd55555;
    opdata2_i = 32'd17;
    start_i = 1'b1;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    check("midrst stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    do_div("after_rst", 32'hDEADBEEF, 32'h1234, 1'b0, 0);
    release_start("after_rst");
    do_div("max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 0);
    release_start("max_1");
    do_div("big_div", 32'hFFFFFFFF, 32'h80000001, 1'b0, 0);
    release_start("big_div");
    do_div("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    release_start("max_max");
    do_div("small", 32'd3, 32'd5, 1'b0, 0);
    release_start("small");
    for (int i = 0; i < 6; i++) begin
      do_div("rand", $urandom, (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28)), 1'($urandom_range(0, 1)), 0);
      release_start("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
